// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I-subset decode stage (lw, sw, R-type, I-type ALU, beq, jal).
// Holds the integer register file and decodes InstrD into control signals,
// operands and a sign-extended immediate. Everything is registered into the
// ID/EX bundle in one cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   InstrD/PCD/PCPlus4D fetch-stage pipeline register contents
//   FlushE              load a bubble into the ID/EX register
//   RegWriteW/RdW/ResultW  write-back port (also bypassed to the reads)
//   *E outputs          registered D->E bundle (all zero for a bubble)
//
// Handshake: there is none. One instruction is accepted every cycle. FlushE
// and reset replace the instruction with a bubble, and there is no stall.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          InstrD,
    input  logic [WORD_SIZE-1:0] PCD,
    input  logic [WORD_SIZE-1:0] PCPlus4D,
    input  logic                 FlushE,
    input  logic                 RegWriteW,
    input  logic [4:0]           RdW,
    input  logic [WORD_SIZE-1:0] ResultW,
    output logic [WORD_SIZE-1:0] RD1E,
    output logic [WORD_SIZE-1:0] RD2E,
    output logic [WORD_SIZE-1:0] ImmExtE,
    output logic [WORD_SIZE-1:0] PCE,
    output logic [WORD_SIZE-1:0] PCPlus4E,
    output logic [4:0]           Rs1E,
    output logic [4:0]           Rs2E,
    output logic [4:0]           RdE,
    output logic                 RegWriteE,
    output logic [1:0]           ResultSrcE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic                 ALUSrcE,
    output logic [2:0]           ALUControlE
);

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_src_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // ------------------------------------------------------------------
    // Register file. Entry 0 is never written, and reads of x0 are forced
    // to zero, so it always reads as zero.
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] rf_q [NUM_REGS];
    logic                 rf_we;

    always_comb begin
        rf_we = RegWriteW && (RdW != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[RdW] <= ResultW;
        end
    end

    // ------------------------------------------------------------------
    // Field extraction, register reads with write-back bypass
    // ------------------------------------------------------------------
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic [4:0]           rs1, rs2, rd;
    logic [WORD_SIZE-1:0] rd1, rd2;

    always_comb begin
        opcode   = InstrD[6:0];
        rd       = InstrD[11:7];
        funct3   = InstrD[14:12];
        rs1      = InstrD[19:15];
        rs2      = InstrD[24:20];
        funct7_5 = InstrD[30];

        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) begin
            rd1 = (rf_we && (RdW == rs1)) ? ResultW : rf_q[rs1];
        end
        if (rs2 != 5'd0) begin
            rd2 = (rf_we && (RdW == rs2)) ? ResultW : rf_q[rs2];
        end
    end

    // ------------------------------------------------------------------
    // Main decode, ALU decode, immediate generation
    // ------------------------------------------------------------------
    logic                 reg_write, mem_write, branch, jump, alu_src;
    logic [1:0]           result_src, alu_op;
    imm_src_e             imm_src;
    logic [2:0]           alu_control;
    logic [WORD_SIZE-1:0] imm_ext;

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        result_src = 2'b00;
        alu_op     = 2'b00;
        imm_src    = IMM_NONE;
        unique case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                imm_src    = IMM_I;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OP_SW: begin
                mem_write = 1'b1;
                imm_src   = IMM_S;
                alu_src   = 1'b1;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                imm_src   = IMM_I;
                alu_src   = 1'b1;
                alu_op    = 2'b10;
            end
            OP_BEQ: begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = 2'b01;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                imm_src    = IMM_J;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    // Only R-type with funct7[5] subtracts; addi ignores bit 30.
                    3'b000:  alu_control = (opcode[5] && funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I: imm_ext = {{(WORD_SIZE-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_ext = {{(WORD_SIZE-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_ext = {{(WORD_SIZE-13){InstrD[31]}}, InstrD[31], InstrD[7],
                              InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: imm_ext = {{(WORD_SIZE-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                              InstrD[20], InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic [WORD_SIZE-1:0] rd1_d, rd2_d, imm_d, pc_d, pc4_d;
    logic [WORD_SIZE-1:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
    logic [4:0]           rs1_d, rs2_d, rdx_d, rs1_q, rs2_q, rdx_q;
    logic                 reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic                 reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
    logic [1:0]           result_src_d, result_src_q;
    logic [2:0]           alu_control_d, alu_control_q;

    always_comb begin
        rd1_d         = rd1;
        rd2_d         = rd2;
        imm_d         = imm_ext;
        pc_d          = PCD;
        pc4_d         = PCPlus4D;
        rs1_d         = rs1;
        rs2_d         = rs2;
        rdx_d         = rd;
        reg_write_d   = reg_write;
        mem_write_d   = mem_write;
        jump_d        = jump;
        branch_d      = branch;
        alu_src_d     = alu_src;
        result_src_d  = result_src;
        alu_control_d = alu_control;
        if (FlushE) begin
            rd1_d         = '0;
            rd2_d         = '0;
            imm_d         = '0;
            pc_d          = '0;
            pc4_d         = '0;
            rs1_d         = '0;
            rs2_d         = '0;
            rdx_d         = '0;
            reg_write_d   = 1'b0;
            mem_write_d   = 1'b0;
            jump_d        = 1'b0;
            branch_d      = 1'b0;
            alu_src_d     = 1'b0;
            result_src_d  = '0;
            alu_control_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            pc4_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rdx_q         <= '0;
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            jump_q        <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            result_src_q  <= '0;
            alu_control_q <= '0;
        end else begin
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            pc4_q         <= pc4_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rdx_q         <= rdx_d;
            reg_write_q   <= reg_write_d;
            mem_write_q   <= mem_write_d;
            jump_q        <= jump_d;
            branch_q      <= branch_d;
            alu_src_q     <= alu_src_d;
            result_src_q  <= result_src_d;
            alu_control_q <= alu_control_d;
        end
    end

    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ImmExtE     = imm_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc4_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rdx_q;
    assign RegWriteE   = reg_write_q;
    assign ResultSrcE  = result_src_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUSrcE     = alu_src_q;
    assign ALUControlE = alu_control_q;

endmodule
